uart_lite_responder: RTL and testbench

// AXI4-Lite responder implementing the UART Lite register map (RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC).

---
 rtl/uart_lite_responder.sv | 212 +++++++++++++++++++++
 tb/tb_uart_lite_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite_responder.sv
`timescale 1ns/1ps
// UART Lite register map behind an AXI4-Lite slave port; RX/TX byte FIFOs face the line side.
// Read data and write responses appear one cycle after the (last) address/data handshake.

// Circular byte FIFO with an extra wrap bit on each pointer; clear overrides push and pop.
// Zero-latency head output; pushes into a full FIFO and pops from an empty one are ignored.
module uart_lite_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module uart_lite_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic [3:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    r_state_t    r_state;
    w_state_t    w_state;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]  rx_head;
    logic        ar_take, rx_pop;
    logic [31:0] rd_dat;
    logic        aw_take, w_take, wr_exec;
    logic [1:0]  aw_addr_q, wr_addr;
    logic [7:0]  w_byte_q, wr_byte;
    logic        w_strb_q, wr_strb0;
    logic        tx_push, ctrl_wr, tx_clr, rx_clr;
    logic        unused_bits;

    assign unused_bits = &{1'b0, s_araddr[1:0], s_awaddr[1:0], s_wdata[31:8], s_wstrb[3:1]};

    assign s_rresp  = 2'b00;
    assign s_bresp  = 2'b00;
    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    assign ar_take = s_arvalid && s_arready;
    assign rx_pop  = ar_take && (s_araddr[3:2] == 2'd0);

    always_comb begin
        rd_dat = 32'd0;
        case (s_araddr[3:2])
            2'd0:    rd_dat = rx_empty ? 32'd0 : {24'd0, rx_head};
            2'd2:    rd_dat = {28'd0, tx_full, tx_empty, rx_full, !rx_empty};
            default: rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b1;
            s_rvalid  <= 1'b0;
            s_rdata   <= 32'd0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_take) begin
                    r_state   <= R_RESP;
                    s_arready <= 1'b0;
                    s_rvalid  <= 1'b1;
                    s_rdata   <= rd_dat;
                end
                R_RESP: if (s_rready) begin
                    r_state   <= R_IDLE;
                    s_arready <= 1'b1;
                    s_rvalid  <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // A channel that is being handshaken this cycle supplies its fields directly, so the
    // action can run in the same cycle as the later of the two handshakes.
    assign aw_take  = s_awvalid && s_awready;
    assign w_take   = s_wvalid && s_wready;
    assign wr_addr  = aw_take ? s_awaddr[3:2] : aw_addr_q;
    assign wr_byte  = w_take ? s_wdata[7:0] : w_byte_q;
    assign wr_strb0 = w_take ? s_wstrb[0] : w_strb_q;
    assign wr_exec  = (w_state == W_IDLE) && (aw_take || !s_awready) && (w_take || !s_wready);
    assign tx_push  = wr_exec && (wr_addr == 2'd1) && wr_strb0;
    assign ctrl_wr  = wr_exec && (wr_addr == 2'd3);
    assign tx_clr   = ctrl_wr && wr_byte[0];
    assign rx_clr   = ctrl_wr && wr_byte[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            s_bvalid  <= 1'b0;
            aw_addr_q <= 2'd0;
            w_byte_q  <= 8'd0;
            w_strb_q  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_take)
                        aw_addr_q <= s_awaddr[3:2];
                    if (w_take) begin
                        w_byte_q <= s_wdata[7:0];
                        w_strb_q <= s_wstrb[0];
                    end
                    if (wr_exec) begin
                        w_state   <= W_RESP;
                        s_bvalid  <= 1'b1;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                    end else begin
                        if (aw_take) s_awready <= 1'b0;
                        if (w_take)  s_wready  <= 1'b0;
                    end
                end
                W_RESP: if (s_bready) begin
                    w_state   <= W_IDLE;
                    s_bvalid  <= 1'b0;
                    s_awready <= 1'b1;
                    s_wready  <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (rx_clr),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (tx_clr),
        .push  (tx_push),
        .din   (wr_byte),
        .pop   (tx_ready),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );
endmodule

// File: tb/tb_uart_lite_responder.sv
`timescale 1ns/1ps
// Directed and random bench for uart_lite_responder against a queue-based register-map model.
module tb_uart_lite_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [3:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_lite_responder #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] stat_model();
        return {28'd0, tx_q.size() == 16, tx_q.size() == 0, rx_q.size() == 16, rx_q.size() != 0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        check("rx_ready", {31'd0, rx_ready}, {31'd0, rx_q.size() < 16});
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        if (rx_q.size() < 16) rx_q.push_back(b);
    endtask

    task automatic do_read(input logic [3:0] addr, input int hold);
        logic [31:0] want;
        want = 32'd0;
        if (addr[3:2] == 2'd2) want = stat_model();
        else if (addr[3:2] == 2'd0 && rx_q.size() != 0) want = {24'd0, rx_q.pop_front()};
        check("arready_idle", {31'd0, s_arready}, 32'd1);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        check("rvalid_lat", {31'd0, s_rvalid}, 32'd1);
        check("arready_busy", {31'd0, s_arready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check("rvalid_hold", {31'd0, s_rvalid}, 32'd1);
            check("rdata_hold", s_rdata, want);
        end
        check("rdata", s_rdata, want);
        check("rresp", {30'd0, s_rresp}, 32'd0);
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        check("rvalid_done", {31'd0, s_rvalid}, 32'd0);
    endtask

    // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W.
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int n;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        n = (lead < 0) ? -lead : lead;
        if (lead == 0) begin
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            step();
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end else begin
            if (lead > 0) s_wvalid = 1'b1; else s_awvalid = 1'b1;
            step();
            if (lead > 0) begin
                s_wvalid = 1'b0;
                check("wready_held", {31'd0, s_wready}, 32'd0);
            end else begin
                s_awvalid = 1'b0;
                check("awready_held", {31'd0, s_awready}, 32'd0);
            end
            check("bvalid_early", {31'd0, s_bvalid}, 32'd0);
            for (int i = 1; i < n; i++) begin
                step();
                check("bvalid_wait", {31'd0, s_bvalid}, 32'd0);
            end
            if (lead > 0) s_awvalid = 1'b1; else s_wvalid = 1'b1;
            step();
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end
        check("bvalid_lat", {31'd0, s_bvalid}, 32'd1);
        check("bresp", {30'd0, s_bresp}, 32'd0);
        if (addr[3:2] == 2'd1 && strb[0] && tx_q.size() < 16) tx_q.push_back(data[7:0]);
        if (addr[3:2] == 2'd3) begin
            if (data[0]) tx_q.delete();
            if (data[1]) rx_q.delete();
        end
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        check("bvalid_done", {31'd0, s_bvalid}, 32'd0);
        check("readies_back", {30'd0, s_awready, s_wready}, 32'd3);
    endtask

    task automatic drain_one();
        check("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});
        if (tx_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0]});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        if (tx_q.size() != 0) void'(tx_q.pop_front());
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {29'd0, s_arready, s_awready, s_wready}, 32'd7);
        check("rst_valid", {30'd0, s_rvalid, s_bvalid}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_resp", {28'd0, s_rresp, s_bresp}, 32'd0);
        check("rst_line", {30'd0, rx_ready, tx_valid}, 32'd2);

        // STAT after reset, response held while rready is low
        do_read(4'h8, 3);

        // RX ordering and empty read
        push_rx(8'h41);
        push_rx(8'h42);
        do_read(4'h8, 0);
        do_read(4'h0, 0);
        do_read(4'h0, 0);
        do_read(4'h0, 0);
        do_read(4'h8, 0);

        // single TX byte, head held until tx_ready
        do_write(4'h4, 32'h1A5, 4'h1, 0);
        check("tx_a5", {23'd0, tx_valid, tx_data}, 32'h1A5);
        step();
        step();
        check("tx_a5_hold", {23'd0, tx_valid, tx_data}, 32'h1A5);
        drain_one();

        // TX overflow: 17th byte dropped
        for (int i = 1; i <= 17; i++) begin
            do_write(4'h4, i, 4'h1, 0);
            if (i == 16) do_read(4'h8, 0);
        end
        for (int i = 1; i <= 16; i++) begin
            check("tx_order", {24'd0, tx_data}, i);
            drain_one();
        end
        drain_one();

        // W ahead of AW, then AW ahead of W with no effect
        do_write(4'h4, 32'h77, 4'h1, 3);
        drain_one();
        do_write(4'h0, 32'h55, 4'h1, -2);
        do_write(4'h4, 32'h66, 4'h0, 1);
        drain_one();

        // RX full, then CTRL clear racing an incoming byte
        for (int i = 0; i < 16; i++) push_rx(8'($urandom));
        check("rx_full_rdy", {31'd0, rx_ready}, 32'd0);
        push_rx(8'hEE);
        rx_data   = 8'h99;
        rx_valid  = 1'b1;
        s_awaddr  = 4'hC;
        s_wdata   = 32'd2;
        s_wstrb   = 4'h1;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        step();
        rx_valid  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        rx_q.delete();
        check("clr_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("clr_bvalid", {31'd0, s_bvalid}, 32'd1);
        s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        do_read(4'h8, 0);

        // random mix of register accesses and line-side traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 5))
                0, 1: push_rx(8'($urandom));
                2: do_read(4'($urandom), $urandom_range(0, 2));
                3: do_write({2'd1, 2'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 4) - 2);
                4: drain_one();
                default: do_write(4'($urandom), ($urandom_range(0, 7) == 0) ? $urandom : 32'd0,
                                  4'($urandom), $urandom_range(0, 2) - 1);
            endcase
        end

        // reset abandons a pending read response and a half-captured write
        push_rx(8'h12);
        do_write(4'h4, 32'h34, 4'h1, 0);
        s_araddr  = 4'h8;
        s_arvalid = 1'b1;
        s_awaddr  = 4'h4;
        s_awvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        check("pre_rst_rvalid", {31'd0, s_rvalid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rx_q.delete();
        tx_q.delete();
        check("mid_rst_valid", {30'd0, s_rvalid, s_bvalid}, 32'd0);
        check("mid_rst_ready", {29'd0, s_arready, s_awready, s_wready}, 32'd7);
        check("mid_rst_line", {30'd0, rx_ready, tx_valid}, 32'd2);
        do_read(4'h8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
